difftest_trap_gen: RTL and testbench
====================================

DIFFTEST_TRAP_GEN -- requirements
Module: difftest_trap_gen

Interface
REQ-001 SHALL have parameter COREID, default 0, meaning 8-bit core id driven on io_coreid.
REQ-002 SHALL have parameter WATCHDOG_CYCLES, default 5000, meaning consecutive no-commit cycles before a timeout trap.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports io_commit_valid_0 and io_commit_valid_1, input, 1 bit each: commit lane valid; lane 0 is older.
REQ-006 SHALL have ports io_commit_instr_0 and io_commit_instr_1, input, 32 bits each: committed instruction.
REQ-007 SHALL have ports io_commit_pc_0 and io_commit_pc_1, input, 64 bits each: committed PC.
REQ-008 SHALL have port io_trapCode, input, 3 bits: a0[2:0] at commit time.
REQ-009 SHALL have port enable, output, 1 bit: qualifier for the trap-event sink.
REQ-010 SHALL have ports io_hasTrap (1), io_hasWFI (1), io_code (3), io_pc (64), io_cycleCnt (64), io_instrCnt (64), io_coreid (8), all outputs: the trap-event payload.

Function
REQ-011 SHALL implement FSM RUN -> REPORT -> HALT; HALT exits only on reset.
REQ-012 All outputs SHALL be registered; a commit in cycle N is reflected in cycle N+1.
REQ-013 In RUN, cycle counter SHALL increment by 1 per cycle, 64-bit wrap-around.
REQ-014 In RUN, instr counter SHALL add the number of counted valid lanes (0, 1 or 2), 64-bit wrap-around.
REQ-015 Trap instruction SHALL be 32'h0000006B on a valid lane.
REQ-016 On a lane-0 trap, lane 1 SHALL NOT be counted or inspected.
REQ-017 On a lane-1 trap, both lanes SHALL be counted.
REQ-018 On a trap: FSM->REPORT; io_hasTrap=1; io_code=io_trapCode; io_pc=trap lane PC; counters include the trap instruction.
REQ-019 REPORT SHALL last exactly one cycle with enable=1, then go to HALT.
REQ-020 In HALT: enable=0, io_hasTrap=0, io_hasWFI=0, counters and payload frozen, commits ignored.
REQ-021 A counted valid lane with instr 32'h10500073 (WFI) SHALL set io_hasWFI=1 for one cycle; otherwise 0.
REQ-022 In RUN, enable SHALL be 1; io_hasTrap SHALL be 0 except in the report cycle.
REQ-023 A last-committed-PC register SHALL track the PC of the youngest counted lane.
REQ-024 io_coreid SHALL equal COREID constantly.

Reset
REQ-025 Reset assertion SHALL take effect asynchronously at any time, including during REPORT or HALT.
REQ-026 Reset SHALL set: FSM=RUN; all counters, last-committed-PC and watchdog = 0; enable, io_hasTrap and io_hasWFI = 0; io_code=0; io_pc=0.
REQ-027 enable SHALL first rise in the first clock after reset_n deasserts.

Configuration
REQ-028 Macro DIFFTEST_WATCHDOG_EN SHALL compile in the no-commit watchdog.
REQ-029 With the macro defined: the watchdog SHALL count RUN cycles with no valid lane and clear on any valid lane.
REQ-030 With the macro defined: at count WATCHDOG_CYCLES-1 with no commit, the block SHALL enter REPORT with io_code=3'd7 and io_pc=last-committed-PC.
REQ-031 With the macro defined: a commit in the expiry cycle SHALL win, clearing the watchdog with no timeout.
REQ-032 Without the macro, no watchdog logic SHALL exist and traps SHALL come only from REQ-015.

Verification
REQ-033 Reset; 10 idle cycles -> enable=1; io_cycleCnt=10; io_instrCnt=0; io_hasTrap=0.
REQ-034 Dual commits for 4 cycles, then lane0 = 0x6B at pc 0x80000100 with trapCode 0 -> one-cycle io_hasTrap, io_code=0, io_pc=0x80000100, io_instrCnt=9; next cycle enable=0.
REQ-035 Lane0 normal, lane1 = 0x6B with trapCode 1 -> io_instrCnt +2, io_pc=lane1 PC, io_code=1.
REQ-036 Lane0 = 0x6B and lane1 = WFI -> io_hasWFI=0, io_instrCnt +1.
REQ-037 With the macro defined and WATCHDOG_CYCLES=8: last commit at pc 0x80000040, then idle -> report with io_code=7, io_pc=0x80000040; a commit on the expiry cycle -> no report.
REQ-038 Assert reset_n low during REPORT -> outputs cleared immediately; after deassertion, counting restarts from 0.

Source files
------------

// File: rtl/difftest_trap_gen.sv
// rtl/difftest_trap_gen.sv - difftest trap/WFI event generator with commit counters (RUN -> REPORT -> HALT)
// Optional no-commit watchdog compiled in with `define DIFFTEST_WATCHDOG_EN.
module difftest_trap_gen #(
  parameter logic [7:0] COREID          = 8'd0,
  parameter int         WATCHDOG_CYCLES = 5000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        io_commit_valid_0,
  input  logic        io_commit_valid_1,
  input  logic [31:0] io_commit_instr_0,
  input  logic [31:0] io_commit_instr_1,
  input  logic [63:0] io_commit_pc_0,
  input  logic [63:0] io_commit_pc_1,
  input  logic [2:0]  io_trapCode,
  output logic        enable,
  output logic        io_hasTrap,
  output logic        io_hasWFI,
  output logic [2:0]  io_code,
  output logic [63:0] io_pc,
  output logic [63:0] io_cycleCnt,
  output logic [63:0] io_instrCnt,
  output logic [7:0]  io_coreid
);

  localparam logic [31:0] TRAP_INSTR = 32'h0000006B;
  localparam logic [31:0] WFI_INSTR  = 32'h10500073;

  typedef enum logic [1:0] {S_RUN, S_REPORT, S_HALT} state_t;

  state_t      state, state_nxt;
  logic [63:0] last_pc, last_pc_nxt;
  logic        enable_nxt, has_trap_nxt, has_wfi_nxt;
  logic [2:0]  code_nxt;
  logic [63:0] pc_nxt, cycle_nxt, instr_nxt;

  logic lane0_trap, lane1_trap, count0, count1, wfi_hit;

  // A lane-0 trap ends the commit group: lane 1 is neither counted nor inspected.
  assign lane0_trap = io_commit_valid_0 && (io_commit_instr_0 == TRAP_INSTR);
  assign count0     = io_commit_valid_0;
  assign count1     = io_commit_valid_1 && !lane0_trap;
  assign lane1_trap = count1 && (io_commit_instr_1 == TRAP_INSTR);
  assign wfi_hit    = (count0 && (io_commit_instr_0 == WFI_INSTR)) ||
                      (count1 && (io_commit_instr_1 == WFI_INSTR));

  assign io_coreid = COREID;

`ifdef DIFFTEST_WATCHDOG_EN
  localparam int WD_W = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);
  logic [WD_W-1:0] wdog, wdog_nxt;
`endif

  always_comb begin
    state_nxt    = state;
    enable_nxt   = 1'b0;
    has_trap_nxt = 1'b0;
    has_wfi_nxt  = 1'b0;
    code_nxt     = io_code;
    pc_nxt       = io_pc;
    cycle_nxt    = io_cycleCnt;
    instr_nxt    = io_instrCnt;
    last_pc_nxt  = last_pc;
`ifdef DIFFTEST_WATCHDOG_EN
    wdog_nxt     = wdog;
`endif
    case (state)
      S_RUN: begin
        enable_nxt  = 1'b1;
        cycle_nxt   = io_cycleCnt + 64'd1;
        instr_nxt   = io_instrCnt + {63'd0, count0} + {63'd0, count1};
        has_wfi_nxt = wfi_hit;
        if (count1)
          last_pc_nxt = io_commit_pc_1;
        else if (count0)
          last_pc_nxt = io_commit_pc_0;
        if (lane0_trap || lane1_trap) begin
          state_nxt    = S_REPORT;
          has_trap_nxt = 1'b1;
          code_nxt     = io_trapCode;
          pc_nxt       = lane0_trap ? io_commit_pc_0 : io_commit_pc_1;
        end
`ifdef DIFFTEST_WATCHDOG_EN
        // Any commit, even on the expiry cycle, restarts the watchdog.
        if (io_commit_valid_0 || io_commit_valid_1) begin
          wdog_nxt = '0;
        end else if (wdog == WD_LAST) begin
          wdog_nxt     = '0;
          state_nxt    = S_REPORT;
          has_trap_nxt = 1'b1;
          code_nxt     = 3'd7;
          pc_nxt       = last_pc;
        end else begin
          wdog_nxt = wdog + 1'b1;
        end
`endif
      end
      S_REPORT: state_nxt = S_HALT;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_RUN;
      enable      <= 1'b0;
      io_hasTrap  <= 1'b0;
      io_hasWFI   <= 1'b0;
      io_code     <= 3'd0;
      io_pc       <= 64'd0;
      io_cycleCnt <= 64'd0;
      io_instrCnt <= 64'd0;
      last_pc     <= 64'd0;
`ifdef DIFFTEST_WATCHDOG_EN
      wdog        <= '0;
`endif
    end else begin
      state       <= state_nxt;
      enable      <= enable_nxt;
      io_hasTrap  <= has_trap_nxt;
      io_hasWFI   <= has_wfi_nxt;
      io_code     <= code_nxt;
      io_pc       <= pc_nxt;
      io_cycleCnt <= cycle_nxt;
      io_instrCnt <= instr_nxt;
      last_pc     <= last_pc_nxt;
`ifdef DIFFTEST_WATCHDOG_EN
      wdog        <= wdog_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_difftest_trap_gen.sv
// tb/tb_difftest_trap_gen.sv - directed self-checking bench for difftest_trap_gen
module tb_difftest_trap_gen;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] TRAP = 32'h0000006B;
  localparam logic [31:0] WFI  = 32'h10500073;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [31:0] i0 = 32'd0, i1 = 32'd0;
  logic [63:0] p0 = 64'd0, p1 = 64'd0;
  logic [2:0]  tcode = 3'd0;

  logic        enable, has_trap, has_wfi;
  logic [2:0]  code;
  logic [63:0] pc, cyc, icnt;
  logic [7:0]  coreid;

  logic        w_enable, w_has_trap, w_has_wfi;
  logic [2:0]  w_code;
  logic [63:0] w_pc, w_cyc, w_icnt;
  logic [7:0]  w_coreid;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  difftest_trap_gen #(.COREID(8'h5A)) dut (
    .clock(clock), .reset_n(reset_n),
    .io_commit_valid_0(v0), .io_commit_valid_1(v1),
    .io_commit_instr_0(i0), .io_commit_instr_1(i1),
    .io_commit_pc_0(p0), .io_commit_pc_1(p1),
    .io_trapCode(tcode),
    .enable(enable), .io_hasTrap(has_trap), .io_hasWFI(has_wfi),
    .io_code(code), .io_pc(pc), .io_cycleCnt(cyc), .io_instrCnt(icnt),
    .io_coreid(coreid)
  );

  difftest_trap_gen #(.COREID(8'h01), .WATCHDOG_CYCLES(8)) dut_wd (
    .clock(clock), .reset_n(reset_n),
    .io_commit_valid_0(v0), .io_commit_valid_1(v1),
    .io_commit_instr_0(i0), .io_commit_instr_1(i1),
    .io_commit_pc_0(p0), .io_commit_pc_1(p1),
    .io_trapCode(tcode),
    .enable(w_enable), .io_hasTrap(w_has_trap), .io_hasWFI(w_has_wfi),
    .io_code(w_code), .io_pc(w_pc), .io_cycleCnt(w_cyc), .io_instrCnt(w_icnt),
    .io_coreid(w_coreid)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic lanes(input logic a_v0, input logic [31:0] a_i0, input logic [63:0] a_p0,
                       input logic a_v1, input logic [31:0] a_i1, input logic [63:0] a_p1,
                       input logic [2:0] a_code);
    v0 = a_v0; i0 = a_i0; p0 = a_p0;
    v1 = a_v1; i1 = a_i1; p1 = a_p1;
    tcode = a_code;
  endtask

  task automatic idle();
    lanes(1'b0, NOP, 64'd0, 1'b0, NOP, 64'd0, 3'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    idle();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_checks++; if (enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable got %b exp 0", enable); end
    n_checks++; if (has_trap !== 1'b0 || has_wfi !== 1'b0) begin n_fail++; $display("FAIL reset_flags got %b%b exp 00", has_trap, has_wfi); end
    n_checks++; if (code !== 3'd0 || pc !== 64'd0) begin n_fail++; $display("FAIL reset_payload got %h/%h exp 0/0", code, pc); end
    n_checks++; if (cyc !== 64'd0 || icnt !== 64'd0) begin n_fail++; $display("FAIL reset_counters got %0d/%0d exp 0/0", cyc, icnt); end
    n_checks++; if (coreid !== 8'h5A) begin n_fail++; $display("FAIL coreid got %h exp 5a", coreid); end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    n_checks++; if (enable !== 1'b0) begin n_fail++; $display("FAIL enable_before_clock got %b exp 0", enable); end
    tick();
    n_checks++; if (enable !== 1'b1 || cyc !== 64'd1) begin n_fail++; $display("FAIL enable_first_clock got %b/%0d exp 1/1", enable, cyc); end
  endtask

  task automatic test_idle();
    do_reset();
    repeat (10) tick();
    n_checks++; if (enable !== 1'b1) begin n_fail++; $display("FAIL idle_enable got %b exp 1", enable); end
    n_checks++; if (cyc !== 64'd10) begin n_fail++; $display("FAIL idle_cycleCnt got %0d exp 10", cyc); end
    n_checks++; if (icnt !== 64'd0) begin n_fail++; $display("FAIL idle_instrCnt got %0d exp 0", icnt); end
    n_checks++; if (has_trap !== 1'b0) begin n_fail++; $display("FAIL idle_hasTrap got %b exp 0", has_trap); end
  endtask

  task automatic test_trap_lane0();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      lanes(1'b1, NOP, 64'h80000000 + 64'(8 * k), 1'b1, NOP, 64'h80000004 + 64'(8 * k), 3'd0);
      tick();
    end
    n_checks++; if (icnt !== 64'd8) begin n_fail++; $display("FAIL dual_instrCnt got %0d exp 8", icnt); end
    lanes(1'b1, TRAP, 64'h80000100, 1'b1, WFI, 64'h80000104, 3'd0);
    tick();
    n_checks++; if (has_trap !== 1'b1 || enable !== 1'b1) begin n_fail++; $display("FAIL l0_report got trap=%b en=%b exp 1/1", has_trap, enable); end
    n_checks++; if (code !== 3'd0 || pc !== 64'h80000100) begin n_fail++; $display("FAIL l0_payload got %0d/%h exp 0/80000100", code, pc); end
    n_checks++; if (icnt !== 64'd9 || cyc !== 64'd5) begin n_fail++; $display("FAIL l0_counts got %0d/%0d exp 9/5", icnt, cyc); end
    n_checks++; if (has_wfi !== 1'b0) begin n_fail++; $display("FAIL l0_wfi_masked got %b exp 0", has_wfi); end
    lanes(1'b1, NOP, 64'h80000200, 1'b1, TRAP, 64'h80000204, 3'd3);
    tick();
    n_checks++; if (enable !== 1'b0 || has_trap !== 1'b0) begin n_fail++; $display("FAIL halt_flags got en=%b trap=%b exp 0/0", enable, has_trap); end
    repeat (2) tick();
    n_checks++; if (icnt !== 64'd9 || cyc !== 64'd5) begin n_fail++; $display("FAIL halt_frozen got %0d/%0d exp 9/5", icnt, cyc); end
    n_checks++; if (code !== 3'd0 || pc !== 64'h80000100 || enable !== 1'b0) begin n_fail++; $display("FAIL halt_payload got %0d/%h/%b exp 0/80000100/0", code, pc, enable); end
    idle();
  endtask

  task automatic test_trap_lane1();
    do_reset();
    lanes(1'b1, WFI, 64'h80000000, 1'b0, NOP, 64'd0, 3'd0);
    tick();
    n_checks++; if (has_wfi !== 1'b1 || icnt !== 64'd1) begin n_fail++; $display("FAIL wfi_set got %b/%0d exp 1/1", has_wfi, icnt); end
    lanes(1'b1, NOP, 64'h80000004, 1'b1, TRAP, 64'h80000008, 3'd1);
    tick();
    n_checks++; if (has_wfi !== 1'b0) begin n_fail++; $display("FAIL wfi_one_cycle got %b exp 0", has_wfi); end
    n_checks++; if (has_trap !== 1'b1 || code !== 3'd1) begin n_fail++; $display("FAIL l1_trap got %b/%0d exp 1/1", has_trap, code); end
    n_checks++; if (pc !== 64'h80000008 || icnt !== 64'd3) begin n_fail++; $display("FAIL l1_payload got %h/%0d exp 80000008/3", pc, icnt); end
    idle();
  endtask

  task automatic test_reset_in_report();
    do_reset();
    lanes(1'b1, TRAP, 64'h80000200, 1'b0, NOP, 64'd0, 3'd5);
    tick();
    n_checks++; if (has_trap !== 1'b1 || code !== 3'd5) begin n_fail++; $display("FAIL pre_reset_report got %b/%0d exp 1/5", has_trap, code); end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (enable !== 1'b0 || has_trap !== 1'b0 || code !== 3'd0 || pc !== 64'd0) begin
      n_fail++; $display("FAIL async_clear got en=%b trap=%b code=%0d pc=%h exp 0/0/0/0", enable, has_trap, code, pc);
    end
    n_checks++; if (cyc !== 64'd0 || icnt !== 64'd0) begin n_fail++; $display("FAIL async_counters got %0d/%0d exp 0/0", cyc, icnt); end
    idle();
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) tick();
    n_checks++; if (enable !== 1'b1 || cyc !== 64'd3 || icnt !== 64'd0) begin n_fail++; $display("FAIL restart got %b/%0d/%0d exp 1/3/0", enable, cyc, icnt); end
  endtask

  task automatic test_watchdog();
    do_reset();
    lanes(1'b1, NOP, 64'h80000040, 1'b0, NOP, 64'd0, 3'd0);
    tick();
    idle();
    repeat (7) tick();
`ifdef DIFFTEST_WATCHDOG_EN
    n_checks++; if (w_has_trap !== 1'b0) begin n_fail++; $display("FAIL wd_early got %b exp 0", w_has_trap); end
    lanes(1'b1, NOP, 64'h80000044, 1'b0, NOP, 64'd0, 3'd0);
    tick();
    n_checks++; if (w_has_trap !== 1'b0 || w_enable !== 1'b1) begin n_fail++; $display("FAIL wd_commit_wins got %b/%b exp 0/1", w_has_trap, w_enable); end
    idle();
    repeat (7) tick();
    n_checks++; if (w_has_trap !== 1'b0) begin n_fail++; $display("FAIL wd_restart got %b exp 0", w_has_trap); end
    tick();
    n_checks++; if (w_has_trap !== 1'b1 || w_code !== 3'd7 || w_pc !== 64'h80000044) begin
      n_fail++; $display("FAIL wd_expire_after_commit got %b/%0d/%h exp 1/7/80000044", w_has_trap, w_code, w_pc);
    end
    do_reset();
    lanes(1'b1, NOP, 64'h80000040, 1'b0, NOP, 64'd0, 3'd0);
    tick();
    idle();
    repeat (8) tick();
    n_checks++; if (w_has_trap !== 1'b1 || w_code !== 3'd7 || w_pc !== 64'h80000040) begin
      n_fail++; $display("FAIL wd_timeout got %b/%0d/%h exp 1/7/80000040", w_has_trap, w_code, w_pc);
    end
    n_checks++; if (w_icnt !== 64'd1 || w_cyc !== 64'd9) begin n_fail++; $display("FAIL wd_counts got %0d/%0d exp 1/9", w_icnt, w_cyc); end
    tick();
    n_checks++; if (w_enable !== 1'b0 || w_has_trap !== 1'b0) begin n_fail++; $display("FAIL wd_halt got %b/%b exp 0/0", w_enable, w_has_trap); end
`else
    repeat (13) tick();
    n_checks++; if (w_has_trap !== 1'b0 || w_enable !== 1'b1) begin n_fail++; $display("FAIL no_watchdog got %b/%b exp 0/1", w_has_trap, w_enable); end
    n_checks++; if (w_cyc !== 64'd21 || w_icnt !== 64'd1) begin n_fail++; $display("FAIL no_watchdog_counts got %0d/%0d exp 21/1", w_cyc, w_icnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_idle();
    test_trap_lane0();
    test_trap_lane1();
    test_reset_in_report();
    test_watchdog();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
